adc_mux_sequencer: RTL and testbench

ADC_MUX_SEQUENCER -- requirements
Module: adc_mux_sequencer

---
 rtl/adc_seq_pkg.sv | 41 ++++
 rtl/adc_period_timer.sv | 29 ++
 rtl/adc_mux_sequencer.sv | 135 +++++++++++++
 tb/tb_adc_mux_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_seq_pkg.sv
// Shared definitions for the ADC mux sequencer and the downstream channel router:
// sequencer states, channel tags and channel-order helpers.
package adc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        START,
        WAIT
    } seq_state_t;

    localparam logic [1:0] CH_X = 2'd0;
    localparam logic [1:0] CH_Y = 2'd1;
    localparam logic [1:0] CH_Z = 2'd2;

    function automatic logic [1:0] first_chan(input logic [2:0] mask);
        if (mask[0]) begin
            return CH_X;
        end else if (mask[1]) begin
            return CH_Y;
        end
        return CH_Z;
    endfunction

    function automatic logic next_exists(input logic [2:0] mask, input logic [1:0] cur);
        case (cur)
            CH_X:    return mask[1] | mask[2];
            CH_Y:    return mask[2];
            default: return 1'b0;
        endcase
    endfunction

    // Only meaningful when next_exists() is true for the same arguments.
    function automatic logic [1:0] next_chan(input logic [2:0] mask, input logic [1:0] cur);
        if (cur == CH_X && mask[1]) begin
            return CH_Y;
        end
        return CH_Z;
    endfunction

endpackage

// File: rtl/adc_period_timer.sv
// Frame-period down-counter: ticks whenever the count is zero while enabled,
// then reloads with period, giving one tick every period+1 cycles.
module adc_period_timer #(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);

    logic [PERIOD_W-1:0] count;

    assign tick = enable && (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!enable) begin
            count <= '0;
        end else if (tick) begin
            count <= period;
        end else begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/adc_mux_sequencer.sv
// Steps the analog mux through the enabled X/Y/Z channels once per frame tick,
// settling the mux, pulsing adc_start and waiting (with timeout) for adc_valid.
module adc_mux_sequencer
    import adc_seq_pkg::*;
#(
    parameter int SETTLE_CYC  = 8,
    parameter int TIMEOUT_CYC = 64,
    parameter int PERIOD_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [2:0]          chan_mask,
    input  logic [PERIOD_W-1:0] period,
    input  logic                adc_valid,
    input  logic                err_clr,
    output logic [1:0]          mux_sel,
    output logic                adc_start,
    output logic                busy,
    output logic                frame_done,
    output logic                timeout_err,
    output logic                overrun_err
);

    localparam int CNT_MAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    seq_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       mask_snap, mask_next;
    logic [1:0]       mux_next;
    logic             tick, advance, done_next, timeout_set, overrun_set;

    adc_period_timer #(.PERIOD_W(PERIOD_W)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .period (period),
        .tick   (tick)
    );

    assign busy      = (state != IDLE);
    assign adc_start = (state == START);

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        mask_next   = mask_snap;
        mux_next    = mux_sel;
        advance     = 1'b0;
        done_next   = 1'b0;
        timeout_set = 1'b0;
        overrun_set = 1'b0;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            if (tick && state != IDLE) begin
                overrun_set = 1'b1;
            end
            case (state)
                IDLE: begin
                    if (tick && chan_mask != 3'b000) begin
                        mask_next  = chan_mask;
                        mux_next   = first_chan(chan_mask);
                        cnt_next   = '0;
                        state_next = SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt_next   = '0;
                        state_next = START;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                START: begin
                    cnt_next   = '0;
                    state_next = WAIT;
                end
                WAIT: begin
                    if (adc_valid) begin
                        advance = 1'b1;
                    end else if (cnt == TIMEOUT_LAST) begin
                        timeout_set = 1'b1;
                        advance     = 1'b1;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
            // mux_sel is only moved on the edge after adc_valid so the router tags correctly.
            if (advance) begin
                cnt_next = '0;
                if (next_exists(mask_snap, mux_sel)) begin
                    mux_next   = next_chan(mask_snap, mux_sel);
                    state_next = SETTLE;
                end else begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            mask_snap   <= 3'b000;
            mux_sel     <= CH_X;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            cnt         <= cnt_next;
            mask_snap   <= mask_next;
            mux_sel     <= mux_next;
            frame_done  <= done_next;
            timeout_err <= timeout_set | (timeout_err & ~err_clr);
            overrun_err <= overrun_set | (overrun_err & ~err_clr);
        end
    end

endmodule

// File: tb/tb_adc_mux_sequencer.sv
// Self-checking bench: a frame-timeline model built with plain arithmetic from the
// channel order, settle time, ADC latency and tick schedule is compared every cycle.
module tb_adc_mux_sequencer;

    localparam int SETTLE = 8;
    localparam int TOUT   = 64;
    localparam int PW     = 16;
    localparam int MAXC   = 1024;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [2:0]    chan_mask;
    logic [PW-1:0] period;
    logic          adc_valid;
    logic          err_clr;
    logic [1:0]    mux_sel;
    logic          adc_start;
    logic          busy;
    logic          frame_done;
    logic          timeout_err;
    logic          overrun_err;

    int checks = 0;
    int errors = 0;

    int         lat [3];
    int         per;
    int         en_cyc;
    int         n_cyc;
    logic [2:0] mask_at [MAXC];
    logic       clr_at [MAXC];

    logic [1:0] exp_mux [MAXC];
    logic       exp_start [MAXC];
    logic       exp_busy [MAXC];
    logic       exp_done [MAXC];
    logic       exp_tout [MAXC];
    logic       exp_ovr [MAXC];
    logic       tout_ev [MAXC];
    logic       ovr_ev [MAXC];
    int         mux_ev [MAXC];

    always #5 clk = ~clk;

    adc_mux_sequencer #(
        .SETTLE_CYC  (SETTLE),
        .TIMEOUT_CYC (TOUT),
        .PERIOD_W    (PW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .chan_mask   (chan_mask),
        .period      (period),
        .adc_valid   (adc_valid),
        .err_clr     (err_clr),
        .mux_sel     (mux_sel),
        .adc_start   (adc_start),
        .busy        (busy),
        .frame_done  (frame_done),
        .timeout_err (timeout_err),
        .overrun_err (overrun_err)
    );

    task automatic checkOutput(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [2:0] m, input logic v, input logic clr);
        enable    = en;
        chan_mask = m;
        adc_valid = v;
        err_clr   = clr;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, " mux_sel"}, int'(mux_sel), 0);
        checkOutput({tag, " adc_start"}, int'(adc_start), 0);
        checkOutput({tag, " busy"}, int'(busy), 0);
        checkOutput({tag, " frame_done"}, int'(frame_done), 0);
        checkOutput({tag, " timeout_err"}, int'(timeout_err), 0);
        checkOutput({tag, " overrun_err"}, int'(overrun_err), 0);
    endtask

    task automatic applyReset();
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkIdleOutputs("reset");
        rst_n = 1'b1;
    endtask

    task automatic fillMask(input logic [2:0] m0, input logic [2:0] m1, input int change_at);
        for (int i = 0; i < MAXC; i++) begin
            mask_at[i] = (i < change_at) ? m0 : m1;
            clr_at[i]  = 1'b0;
        end
    endtask

    // Frame timeline: each accepted tick at tk walks the snapshot channels in order;
    // a channel occupies SETTLE cycles, one start cycle, then lat (or TOUT) wait cycles.
    task automatic buildModel();
        int busy_lo = 1;
        int busy_hi = 0;
        int s;
        int st;
        int comp;
        logic [1:0] m;
        logic t;
        logic o;
        for (int i = 0; i < MAXC; i++) begin
            exp_start[i] = 1'b0;
            exp_busy[i]  = 1'b0;
            exp_done[i]  = 1'b0;
            tout_ev[i]   = 1'b0;
            ovr_ev[i]    = 1'b0;
            mux_ev[i]    = -1;
        end
        for (int tk = en_cyc; tk < n_cyc; tk += per + 1) begin
            if (mask_at[tk] == 3'b000) continue;
            if (tk >= busy_lo && tk <= busy_hi) begin
                ovr_ev[tk] = 1'b1;
                continue;
            end
            s = tk + 1;
            for (int ch = 0; ch < 3; ch++) begin
                if (mask_at[tk][ch]) begin
                    mux_ev[s] = ch;
                    st = s + SETTLE;
                    exp_start[st] = 1'b1;
                    if (lat[ch] >= 1 && lat[ch] <= TOUT) begin
                        comp = st + lat[ch];
                    end else begin
                        comp = st + TOUT;
                        tout_ev[comp] = 1'b1;
                    end
                    s = comp + 1;
                end
            end
            exp_done[s] = 1'b1;
            busy_lo = tk + 1;
            busy_hi = s - 1;
            for (int c = busy_lo; c <= busy_hi; c++) exp_busy[c] = 1'b1;
        end
        m = 2'd0;
        t = 1'b0;
        o = 1'b0;
        for (int c = 0; c < n_cyc; c++) begin
            if (mux_ev[c] >= 0) m = 2'(mux_ev[c]);
            exp_mux[c]  = m;
            exp_tout[c] = t;
            exp_ovr[c]  = o;
            t = tout_ev[c] | (t & ~clr_at[c]);
            o = ovr_ev[c] | (o & ~clr_at[c]);
        end
    endtask

    task automatic runScenario(input string name);
        int valid_at = -1;
        int idx;
        buildModel();
        period = PW'(per);
        applyReset();
        for (int c = 0; c < n_cyc; c++) begin
            @(posedge clk);
            #1;
            applyStimulus(c >= en_cyc, mask_at[c], c == valid_at, clr_at[c]);
            @(negedge clk);
            checkOutput($sformatf("%s mux_sel c%0d", name, c), int'(mux_sel), int'(exp_mux[c]));
            checkOutput($sformatf("%s adc_start c%0d", name, c), int'(adc_start), int'(exp_start[c]));
            checkOutput($sformatf("%s busy c%0d", name, c), int'(busy), int'(exp_busy[c]));
            checkOutput($sformatf("%s frame_done c%0d", name, c), int'(frame_done), int'(exp_done[c]));
            checkOutput($sformatf("%s timeout_err c%0d", name, c), int'(timeout_err), int'(exp_tout[c]));
            checkOutput($sformatf("%s overrun_err c%0d", name, c), int'(overrun_err), int'(exp_ovr[c]));
            idx = int'(mux_sel);
            if (adc_start === 1'b1 && idx <= 2 && lat[idx] > 0) valid_at = c + lat[idx];
        end
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n  = 1'b0;
        period = '0;
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b0);

        // All three channels, fast ADC.
        for (int i = 0; i < 3; i++) lat[i] = 10;
        per = 99; en_cyc = 3; n_cyc = 350;
        fillMask(3'b111, 3'b111, 0);
        runScenario("mask111");

        // X and Z only, random latencies.
        for (int i = 0; i < 3; i++) lat[i] = int'($urandom_range(1, 20));
        per = int'($urandom_range(80, 120)); en_cyc = 0; n_cyc = 400;
        fillMask(3'b101, 3'b101, 0);
        runScenario("mask101");

        // Silent on Y: timeout, Z still sampled.
        lat[0] = 10; lat[1] = 0; lat[2] = 10;
        per = 199; en_cyc = 2; n_cyc = 450;
        fillMask(3'b111, 3'b111, 0);
        runScenario("ysilent");

        // Period shorter than a frame: overruns, plain clear and clear against a set.
        for (int i = 0; i < 3; i++) lat[i] = 10;
        per = 20; en_cyc = 1; n_cyc = 300;
        fillMask(3'b111, 3'b111, 0);
        clr_at[en_cyc + 50]  = 1'b1;
        clr_at[en_cyc + 105] = 1'b1;
        runScenario("overrun");

        // Empty mask: nothing ever starts.
        per = 30; en_cyc = 0; n_cyc = 520;
        fillMask(3'b000, 3'b000, 0);
        runScenario("mask000");

        // Random configurations, mid-run mask change, stray clears.
        for (int k = 0; k < 4; k++) begin
            per = int'($urandom_range(15, 150));
            en_cyc = int'($urandom_range(0, 10));
            n_cyc = 600;
            fillMask(3'($urandom_range(0, 7)), 3'($urandom_range(1, 7)), int'($urandom_range(50, 400)));
            for (int i = 0; i < 3; i++) lat[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 72));
            for (int j = 0; j < 3; j++) clr_at[$urandom_range(0, 599)] = 1'b1;
            runScenario($sformatf("rand%0d", k));
        end

        // enable dropped mid-SETTLE of channel Y.
        period = PW'(99);
        applyReset();
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            applyStimulus(c < 4, 3'b110, 1'b0, 1'b0);
            @(negedge clk);
            checkOutput($sformatf("abort busy c%0d", c), int'(busy), int'(c >= 1 && c <= 4));
            if (c >= 1) checkOutput($sformatf("abort mux_sel c%0d", c), int'(mux_sel), 1);
            checkOutput($sformatf("abort adc_start c%0d", c), int'(adc_start), 0);
            checkOutput($sformatf("abort frame_done c%0d", c), int'(frame_done), 0);
        end

        // Asynchronous reset in the middle of a WAIT.
        applyReset();
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            applyStimulus(1'b1, 3'b010, 1'b0, 1'b0);
        end
        @(negedge clk);
        checkOutput("prereset busy", int'(busy), 1);
        checkOutput("prereset mux_sel", int'(mux_sel), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkIdleOutputs("asyncreset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
